// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_pkg
//  Description : Shared AHB transfer/burst encodings, arbiter FSM states and
//                the burst-length decode used by ahb_arbiter_mp.
//  Revision    : 1.0 - initial release
// ============================================================================
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_e;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BURST  = 2'd1,
        ARB_INCR   = 2'd2,
        ARB_LOCKED = 2'd3
    } arb_state_e;

    // Beats in a fixed-length burst; SINGLE and undefined-length INCR map to 1
    function automatic logic [4:0] burst_len(input hburst_e burst);
        logic [4:0] len;
        case (burst)
            HBURST_WRAP4,  HBURST_INCR4:  len = 5'd4;
            HBURST_WRAP8,  HBURST_INCR8:  len = 5'd8;
            HBURST_WRAP16, HBURST_INCR16: len = 5'd16;
            default:                      len = 5'd1;
        endcase
        return len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_arb_pick.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_arb_pick
//  Description : Combinational winner selection. A starving requester (lowest
//                index) overrides everything; otherwise fixed priority (lowest
//                index) or round robin starting after i_rr_ptr. With no
//                request the default master is returned with o_valid low.
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_arb_pick import ahb_pkg::*; #(
    parameter int NUM_MASTERS    = 4,
    parameter int MASTER_W       = 2,
    parameter int ARB_MODE       = 0,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic [MASTER_W-1:0]    i_rr_ptr,
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic [NUM_MASTERS-1:0] i_starve,
    output logic [MASTER_W-1:0]    o_idx,
    output logic                   o_valid
);

    logic [MASTER_W:0] w_pos;

    // Scan requesters; the wrap is folded back explicitly so no index leaves range
    always_comb begin
        o_idx   = MASTER_W'(DEFAULT_MASTER);
        o_valid = 1'b0;
        w_pos   = '0;
        if (|i_starve) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (i_starve[i] && !o_valid) begin
                    o_idx   = MASTER_W'(i);
                    o_valid = 1'b1;
                end
            end
        end else if (ARB_MODE == 1) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (i_req[i] && !o_valid) begin
                    o_idx   = MASTER_W'(i);
                    o_valid = 1'b1;
                end
            end
        end else begin
            for (int k = 1; k <= NUM_MASTERS; k++) begin
                w_pos = {1'b0, i_rr_ptr} + (MASTER_W+1)'(k);
                if (w_pos >= (MASTER_W+1)'(NUM_MASTERS)) begin
                    w_pos = w_pos - (MASTER_W+1)'(NUM_MASTERS);
                end
                if (i_req[w_pos[MASTER_W-1:0]] && !o_valid) begin
                    o_idx   = w_pos[MASTER_W-1:0];
                    o_valid = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ahb_arbiter_mp.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_arbiter_mp
//  Description : Multi-master AHB arbiter: round-robin or fixed priority,
//                registered one-hot grant, burst/lock tracking FSM and
//                default-master parking. Optional starvation guard enabled
//                by defining AHB_ARB_STARVE_EN (adds STARVE_LIMIT).
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_arbiter_mp import ahb_pkg::*; #(
    parameter  int NUM_MASTERS    = 4,
    parameter  int ARB_MODE       = 0,
    parameter  int DEFAULT_MASTER = 0,
`ifdef AHB_ARB_STARVE_EN
    parameter  int STARVE_LIMIT   = 8,
`endif
    localparam int MASTER_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                   Hclk,
    input  logic                   Hresetn,
    input  logic [NUM_MASTERS-1:0] Hreq,
    input  logic [NUM_MASTERS-1:0] Hlock,
    input  logic                   Hready,
    input  logic [1:0]             Htrans,
    input  logic [2:0]             Hburst,
    output logic [NUM_MASTERS-1:0] Hgrant,
    output logic [MASTER_W-1:0]    Hmaster,
    output logic                   Hmastlock
);

    localparam logic [NUM_MASTERS-1:0] c_default_oh  = NUM_MASTERS'(1) << DEFAULT_MASTER;
    localparam logic [MASTER_W-1:0]    c_default_idx = MASTER_W'(DEFAULT_MASTER);

    arb_state_e             r_state, w_state_nxt, w_ns_state;
    logic [4:0]             r_beats, w_beats_nxt, w_ns_beats;
    logic [NUM_MASTERS-1:0] r_grant, w_win_oh, w_starve;
    logic [MASTER_W-1:0]    r_hmaster, r_rr_ptr, w_win_idx, w_grant_idx;
    logic                   r_hmastlock, w_win_valid, w_arb_open, w_window;
    htrans_e                w_htrans;
    hburst_e                w_hburst;

    assign w_htrans  = htrans_e'(Htrans);
    assign w_hburst  = hburst_e'(Hburst);
    assign w_window  = Hready && w_arb_open;
    assign Hgrant    = r_grant;
    assign Hmaster   = r_hmaster;
    assign Hmastlock = r_hmastlock;

    // Where a NONSEQ from the owner leads; lock wins over burst tracking
    always_comb begin
        w_ns_state = ARB_IDLE;
        w_ns_beats = '0;
        if (Hlock[r_hmaster]) begin
            w_ns_state = ARB_LOCKED;
        end else if (w_hburst == HBURST_INCR) begin
            w_ns_state = ARB_INCR;
        end else if (w_hburst != HBURST_SINGLE) begin
            w_ns_state = ARB_BURST;
            w_ns_beats = burst_len(w_hburst) - 5'd1;
        end
    end

    // Next-state logic; nothing moves on a wait-stated cycle
    always_comb begin
        w_state_nxt = r_state;
        w_beats_nxt = r_beats;
        if (Hready) begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_htrans == HTRANS_NONSEQ) begin
                        w_state_nxt = w_ns_state;
                        w_beats_nxt = w_ns_beats;
                    end
                end
                ARB_BURST: begin
                    case (w_htrans)
                        HTRANS_SEQ: begin
                            if (r_beats <= 5'd1) begin
                                w_state_nxt = ARB_IDLE;
                                w_beats_nxt = '0;
                            end else begin
                                w_beats_nxt = r_beats - 5'd1;
                            end
                        end
                        HTRANS_IDLE: begin
                            w_state_nxt = ARB_IDLE;
                            w_beats_nxt = '0;
                        end
                        HTRANS_NONSEQ: begin
                            w_state_nxt = w_ns_state;
                            w_beats_nxt = w_ns_beats;
                        end
                        default: ;
                    endcase
                end
                ARB_INCR: begin
                    if (w_htrans == HTRANS_IDLE) begin
                        w_state_nxt = ARB_IDLE;
                    end else if (w_htrans == HTRANS_NONSEQ) begin
                        w_state_nxt = w_ns_state;
                        w_beats_nxt = w_ns_beats;
                    end
                end
                default: begin
                    if (!Hlock[r_hmaster] && (w_htrans != HTRANS_SEQ) &&
                        (w_htrans != HTRANS_BUSY)) begin
                        w_state_nxt = ARB_IDLE;
                    end
                end
            endcase
        end
    end

    // Arbitration window: never while a locked sequence owns the bus
    always_comb begin
        w_arb_open = (r_state != ARB_LOCKED) &&
                     ((w_state_nxt == ARB_IDLE) ||
                      ((r_state == ARB_BURST) && (r_beats == 5'd0) && (w_htrans == HTRANS_SEQ)) ||
                      ((r_state == ARB_INCR) && !Hreq[r_hmaster]));
    end

`ifdef AHB_ARB_STARVE_EN
    localparam int c_wait_w = $clog2(STARVE_LIMIT + 1);

    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_wait
        logic [c_wait_w-1:0] r_wait;
        // Count windows lost while requesting; cleared on grant or release
        always_ff @(posedge Hclk) begin
            if (!Hresetn || !Hreq[gi]) begin
                r_wait <= '0;
            end else if (w_window) begin
                if (w_win_idx == MASTER_W'(gi)) begin
                    r_wait <= '0;
                end else if (r_wait != c_wait_w'(STARVE_LIMIT)) begin
                    r_wait <= r_wait + 1'b1;
                end
            end
        end
        assign w_starve[gi] = Hreq[gi] && (r_wait == c_wait_w'(STARVE_LIMIT));
    end
`else
    assign w_starve = '0;
`endif

    ahb_arb_pick #(
        .NUM_MASTERS    (NUM_MASTERS),
        .MASTER_W       (MASTER_W),
        .ARB_MODE       (ARB_MODE),
        .DEFAULT_MASTER (DEFAULT_MASTER)
    ) u_pick (
        .i_rr_ptr (r_rr_ptr),
        .i_req    (Hreq),
        .i_starve (w_starve),
        .o_idx    (w_win_idx),
        .o_valid  (w_win_valid)
    );

    // One-hot of the winner and index of the current grant
    always_comb begin
        w_win_oh            = '0;
        w_win_oh[w_win_idx] = 1'b1;
        w_grant_idx         = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (r_grant[i]) begin
                w_grant_idx = MASTER_W'(i);
            end
        end
    end

    // FSM state register
    always_ff @(posedge Hclk) begin
        if (!Hresetn) begin
            r_state <= ARB_IDLE;
            r_beats <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_beats <= w_beats_nxt;
        end
    end

    // Grant, round-robin pointer and address-phase ownership registers
    always_ff @(posedge Hclk) begin
        if (!Hresetn) begin
            r_grant     <= c_default_oh;
            r_rr_ptr    <= c_default_idx;
            r_hmaster   <= c_default_idx;
            r_hmastlock <= 1'b0;
        end else begin
            if (w_window) begin
                r_grant <= w_win_oh;
                if (w_win_valid) begin
                    r_rr_ptr <= w_win_idx;
                end
            end
            if (Hready) begin
                r_hmaster   <= w_grant_idx;
                r_hmastlock <= Hlock[w_grant_idx];
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/ahb_arbiter_mp.md
Name: ahb_arbiter_mp

Overview:
- Parametrised multi-master AHB arbiter and successor of the single-mode round-robin arbiter.
- Adds:
  - selectable round-robin / fixed-priority mode
  - registered one-hot grant
  - explicit burst FSM with early-termination handling
  - locked-transfer support
  - default-master parking
- Sits between the master-side request lines and the address/control mux, which is steered by Hmaster.

Parameters:
- NUM_MASTERS, 4, number of masters (2..16).
- ARB_MODE, 0, 0 = round robin, 1 = fixed priority (index 0 highest).
- DEFAULT_MASTER, 0, master parked on when no request is pending.
- MASTER_W, (NUM_MASTERS>1 ? $clog2(NUM_MASTERS) : 1), index width; derived, not overridden.

Ports:
- Hclk  in  1  bus clock.
- Hresetn  in  1  reset; synchronous, active-low.
- Hreq  in  NUM_MASTERS  per-master bus request.
- Hlock  in  NUM_MASTERS  per-master locked-transfer request.
- Hready  in  1  global transfer-done.
- Htrans  in  2  transfer type of the current owner.
- Hburst  in  3  burst type of the current owner.
- Hgrant  out  NUM_MASTERS  registered one-hot grant.
- Hmaster  out  MASTER_W  index of the master owning the address phase.
- Hmastlock  out  1  current address phase is locked.

Behaviour:
- Interface: one clock, Hclk. Reset Hresetn is synchronous, active-low and sampled only on the Hclk rising edge.
- Reset values: Hgrant = one-hot(DEFAULT_MASTER); Hmaster = DEFAULT_MASTER; Hmastlock = 0; FSM = ARB_IDLE; beats_left = 0; rr_ptr = DEFAULT_MASTER.
- Reset mid-burst or mid-lock: everything returns to the reset values above on the next edge.
- FSM states: ARB_IDLE, ARB_BURST (fixed length), ARB_INCR (undefined length), ARB_LOCKED.
- Transfer detection: all transitions are qualified by Hready=1, except the LOCKED exit, which also requires Hready=1. "Owner" is Hmaster.
- From ARB_IDLE, on Htrans=NONSEQ:
  - If Hlock[owner]=1: go to ARB_LOCKED. Lock takes priority over burst tracking.
  - Else if Hburst=SINGLE: stay in ARB_IDLE.
  - Else if Hburst=INCR (001): go to ARB_INCR.
  - Else: go to ARB_BURST with beats_left = len-1, where len is 4/8/16 for WRAP/INCR 4/8/16.
- In ARB_BURST:
  - SEQ decrements beats_left.
  - BUSY holds beats_left.
  - IDLE (early termination) goes to ARB_IDLE.
  - NONSEQ reloads per the ARB_IDLE rules.
  - When beats_left=0 is reached on the last SEQ, go to ARB_IDLE.
- In ARB_INCR: exit to ARB_IDLE when Htrans is IDLE or NONSEQ. A NONSEQ is re-evaluated as in ARB_IDLE.
- In ARB_LOCKED: stay while Hlock[owner]=1. Exit to ARB_IDLE when Hlock[owner]=0 and Htrans is not SEQ/BUSY.
- Arbitration window (arb_open), open when any of:
  - next state is ARB_IDLE
  - in ARB_BURST with beats_left=0 and SEQ
  - in ARB_INCR with Hreq[owner]=0
  - arb_open is never asserted while in ARB_LOCKED.
- Grant update: when Hready=1 and arb_open, Hgrant <= one-hot(winner) on the next edge. Otherwise Hgrant holds. Grant latency is one cycle.
- Winner selection:
  - Round robin: first set Hreq scanning rr_ptr+1 .. rr_ptr+NUM_MASTERS, computed mod NUM_MASTERS with no out-of-range index.
  - Fixed priority: lowest set index.
  - No request: DEFAULT_MASTER.
- rr_ptr update: rr_ptr <= winner only when the winner had Hreq set. Parking does not move rr_ptr.
- Ownership: Hmaster <= index(Hgrant) and Hmastlock <= Hlock[index(Hgrant)] on every edge with Hready=1. With Hready=0, both hold.
- Simultaneous events:
  - Owner requesting in the window competes normally. In round robin it is last in scan order.
  - A request arriving in the same cycle the window opens is considered.
  - Hgrant is always exactly one-hot.

Optional Feature:
- Macro: AHB_ARB_STARVE_EN. Adds parameter STARVE_LIMIT (default 8) and a per-master wait counter.
- Wait counter behaviour:
  - Increments on each window where that master requested but lost.
  - Clears when the master is granted or drops Hreq.
  - Saturates at STARVE_LIMIT.
- When any counter reaches STARVE_LIMIT, the lowest such index wins the next window, overriding ARB_MODE.
- Without the macro, there are no counters and selection is purely per ARB_MODE.

Decomposition:
- Package ahb_pkg holds:
  - htrans_e (IDLE/BUSY/NONSEQ/SEQ)
  - hburst_e
  - arb_state_e
  - a burst_len function (Hburst -> 5-bit length)
- Sub-module ahb_arb_pick: combinational winner selection (mode, rr_ptr, Hreq, optional starve vector -> index, valid).
- The top module holds the FSM, counters and registers.

Test Plan:
- Reset with NUM_MASTERS=4, DEFAULT_MASTER=2, no requests -> Hgrant=0100, Hmaster=2, Hmastlock=0. A synchronous check: deasserting Hresetn between edges changes nothing until the next edge.
- Round robin, Hreq=1111, owner 0, single NONSEQ transfers -> grants cycle 1,2,3,0 one cycle after each window; no master is skipped.
- Master 1 issues INCR8 with Hreq=1111 and Hready toggling 0/1 -> Hgrant held for exactly 8 Hready-qualified beats; re-arbitration on the 8th beat; BUSY beats not counted.
- INCR8 terminated by IDLE after 3 beats -> FSM returns to ARB_IDLE; the next requester is granted on the following cycle.
- Hlock[3]=1 with INCR burst and other requests pending -> Hgrant stays 1000 and Hmastlock=1 until Hlock[3] drops with Htrans=IDLE.
- ARB_MODE=1 with Hreq=0110 -> master 1 always wins. With AHB_ARB_STARVE_EN and STARVE_LIMIT=3, master 2 is granted on the 4th window.
